// File: rtl/real_clock_keeper_if.sv
// Time-load handshake bundle for real_clock_keeper.
// master: requester drives set_valid/set_hour/set_min/set_sec, sees set_ready/set_err.
// slave : clock keeper accepts on set_valid & set_ready, pulses set_err on a bad load.
interface real_clock_keeper_if;
    logic       set_valid;
    logic       set_ready;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic [5:0] set_sec;
    logic       set_err;

    modport master (
        output set_valid, set_hour, set_min, set_sec,
        input  set_ready, set_err
    );

    modport slave (
        input  set_valid, set_hour, set_min, set_sec,
        output set_ready, set_err
    );
endinterface

// File: rtl/real_clock_keeper.sv
// Real-time clock keeper: counts usr_clk seconds into hour/min/sec, with load handshake.
// Ports: clk, reset (async, active-low), usr_clk (async seconds clock), run,
//   set_if (load handshake), hour/min/sec, sec_tick, day_wrap,
//   alarm_hour/alarm_min/alarm_ack/alarm.
// Optional alarm: define REAL_CLOCK_ALARM_EN; otherwise alarm is tied 0.
module real_clock_keeper #(
    parameter int SYNC_STAGES = 2,
    parameter int HOUR_MAX    = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 usr_clk,
    input  logic                 run,
    real_clock_keeper_if.slave   set_if,
    input  logic [4:0]           alarm_hour,
    input  logic [5:0]           alarm_min,
    input  logic                 alarm_ack,
    output logic [4:0]           hour,
    output logic [5:0]           min,
    output logic [5:0]           sec,
    output logic                 sec_tick,
    output logic                 day_wrap,
    output logic                 alarm
);

    localparam logic [4:0] LP_HMAX = 5'(HOUR_MAX);
    localparam logic [5:0] LP_59   = 6'd59;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PAUSE,
        ST_LOAD
    } state_t;

    state_t r_state;
    state_t w_nxt;

    logic [SYNC_STAGES-1:0] r_sync;
    // r_vld marks which sync stages hold real post-reset samples,
    // so the reset-zero contents can never arm the edge detector.
    logic [SYNC_STAGES-1:0] r_vld;
    logic                   r_hist;
    logic                   r_armed;
    logic                   r_rise;

    logic [4:0] r_hour;
    logic [5:0] r_min;
    logic [5:0] r_sec;
    logic       r_sec_tick;
    logic       r_day_wrap;
    logic       r_set_err;

    logic w_synced;
    logic w_ready;
    logic w_xfer;
    logic w_in_rng;
    logic w_load;
    logic w_bad;
    logic w_count;
    logic w_sec_w;
    logic w_min_w;
    logic w_hr_w;

    assign w_synced = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync  <= '0;
            r_vld   <= '0;
            r_hist  <= 1'b0;
            r_armed <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], usr_clk};
            r_vld   <= {r_vld[SYNC_STAGES-2:0], 1'b1};
            r_hist  <= w_synced;
            r_armed <= r_armed | (r_vld[SYNC_STAGES-1] & ~w_synced);
            // Registered edge keeps the counted second a fixed
            // SYNC_STAGES+1 edges behind the first high sample.
            r_rise  <= w_synced & ~r_hist & r_armed;
        end
    end

    always_comb begin
        w_ready  = (r_state != ST_LOAD);
        w_xfer   = set_if.set_valid & w_ready;
        w_in_rng = (set_if.set_hour <= LP_HMAX) &&
                   (set_if.set_min  <= LP_59) &&
                   (set_if.set_sec  <= LP_59);
        w_load   = w_xfer & w_in_rng;
        w_bad    = w_xfer & ~w_in_rng;
        // A tick is counted only while running; load wins over a tick.
        w_count  = r_rise & run & (r_state == ST_RUN) & ~w_load;
        w_sec_w  = (r_sec == LP_59);
        w_min_w  = (r_min == LP_59);
        w_hr_w   = (r_hour == LP_HMAX);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            ST_RUN: begin
                if (w_load) begin
                    w_nxt = ST_LOAD;
                end else if (!run) begin
                    w_nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (w_load) begin
                    w_nxt = ST_LOAD;
                end else if (run) begin
                    w_nxt = ST_RUN;
                end
            end
            ST_LOAD: begin
                w_nxt = run ? ST_RUN : ST_PAUSE;
            end
            default: begin
                w_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hour     <= '0;
            r_min      <= '0;
            r_sec      <= '0;
            r_sec_tick <= 1'b0;
            r_day_wrap <= 1'b0;
            r_set_err  <= 1'b0;
        end else begin
            r_sec_tick <= w_count;
            r_day_wrap <= w_count & w_sec_w & w_min_w & w_hr_w;
            r_set_err  <= w_bad;
            if (w_load) begin
                r_hour <= set_if.set_hour;
                r_min  <= set_if.set_min;
                r_sec  <= set_if.set_sec;
            end else if (w_count) begin
                if (w_sec_w) begin
                    r_sec <= '0;
                    if (w_min_w) begin
                        r_min  <= '0;
                        r_hour <= w_hr_w ? 5'd0 : r_hour + 5'd1;
                    end else begin
                        r_min <= r_min + 6'd1;
                    end
                end else begin
                    r_sec <= r_sec + 6'd1;
                end
            end
        end
    end

`ifdef REAL_CLOCK_ALARM_EN
    logic r_alarm;

    // Checked the cycle after the counted tick lands on hh:mm:00.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alarm <= 1'b0;
        end else if (alarm_ack) begin
            r_alarm <= 1'b0;
        end else if (r_sec_tick && (r_sec == 6'd0) &&
                     (r_hour == alarm_hour) && (r_min == alarm_min)) begin
            r_alarm <= 1'b1;
        end
    end

    assign alarm = r_alarm;
`else
    logic w_unused;

    assign w_unused = ^{alarm_hour, alarm_min, alarm_ack};
    assign alarm    = 1'b0;
`endif

    assign set_if.set_ready = w_ready;
    assign set_if.set_err   = r_set_err;
    assign hour             = r_hour;
    assign min              = r_min;
    assign sec              = r_sec;
    assign sec_tick         = r_sec_tick;
    assign day_wrap         = r_day_wrap;

endmodule
